// File: rtl/seven_segments_pkg.sv
// rtl/seven_segments_pkg.sv - segment pattern constants and types for seven_segments
package seven_segments_pkg;

    // Segment vector, bit0=a ... bit6=g, active-high (1 = segment lit)
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h00;

    localparam seg_t SEG_HEX_0 = 7'h3F;
    localparam seg_t SEG_HEX_1 = 7'h06;
    localparam seg_t SEG_HEX_2 = 7'h5B;
    localparam seg_t SEG_HEX_3 = 7'h4F;
    localparam seg_t SEG_HEX_4 = 7'h66;
    localparam seg_t SEG_HEX_5 = 7'h6D;
    localparam seg_t SEG_HEX_6 = 7'h7D;
    localparam seg_t SEG_HEX_7 = 7'h07;
    localparam seg_t SEG_HEX_8 = 7'h7F;
    localparam seg_t SEG_HEX_9 = 7'h6F;
    localparam seg_t SEG_HEX_A = 7'h77;
    localparam seg_t SEG_HEX_B = 7'h7C;
    localparam seg_t SEG_HEX_C = 7'h39;
    localparam seg_t SEG_HEX_D = 7'h5E;
    localparam seg_t SEG_HEX_E = 7'h79;
    localparam seg_t SEG_HEX_F = 7'h71;

    // Keyboard operator glyphs for codes 10-15
    localparam seg_t SEG_GLYPH_PLUS  = 7'h46;
    localparam seg_t SEG_GLYPH_MINUS = 7'h40;
    localparam seg_t SEG_GLYPH_MUL   = 7'h76;
    localparam seg_t SEG_GLYPH_DIV   = 7'h52;
    localparam seg_t SEG_GLYPH_ENTER = 7'h48;
    localparam seg_t SEG_GLYPH_ESC   = 7'h39;

    // Map an active-high pattern onto the board's drive polarity
    function automatic seg_t apply_polarity(input seg_t seg, input bit active_low);
        return active_low ? ~seg : seg;
    endfunction

endpackage

// File: rtl/seven_segments_rom.sv
// rtl/seven_segments_rom.sv - digit code to active-high segment pattern; SEVEN_SEGMENTS_OPGLYPH_EN selects operator glyphs for 10-15
module seven_segments_rom
    import seven_segments_pkg::*;
(
    input  logic [3:0] digit,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_OFF;
        case (digit)
            4'd0:  seg = SEG_HEX_0;
            4'd1:  seg = SEG_HEX_1;
            4'd2:  seg = SEG_HEX_2;
            4'd3:  seg = SEG_HEX_3;
            4'd4:  seg = SEG_HEX_4;
            4'd5:  seg = SEG_HEX_5;
            4'd6:  seg = SEG_HEX_6;
            4'd7:  seg = SEG_HEX_7;
            4'd8:  seg = SEG_HEX_8;
            4'd9:  seg = SEG_HEX_9;
`ifdef SEVEN_SEGMENTS_OPGLYPH_EN
            4'd10: seg = SEG_GLYPH_PLUS;
            4'd11: seg = SEG_GLYPH_MINUS;
            4'd12: seg = SEG_GLYPH_MUL;
            4'd13: seg = SEG_GLYPH_DIV;
            4'd14: seg = SEG_GLYPH_ENTER;
            4'd15: seg = SEG_GLYPH_ESC;
`else
            4'd10: seg = SEG_HEX_A;
            4'd11: seg = SEG_HEX_B;
            4'd12: seg = SEG_HEX_C;
            4'd13: seg = SEG_HEX_D;
            4'd14: seg = SEG_HEX_E;
            4'd15: seg = SEG_HEX_F;
`endif
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seven_segments.sv
// rtl/seven_segments.sv - registered single-digit seven-segment driver with blanking (optional SEVEN_SEGMENTS_OPGLYPH_EN)
module seven_segments
    import seven_segments_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] digit,
    input  logic       load,
    input  logic       blank,
    output logic [6:0] Seven
);

    localparam seg_t DRIVE_OFF = ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;

    logic [3:0] digit_q;
    logic       shown;
    seg_t       seg_q;

    logic [3:0] digit_nxt;
    logic       shown_nxt;
    seg_t       rom_seg;

    // Decode the post-edge digit so a load is visible one edge after it is sampled
    assign digit_nxt = load ? digit : digit_q;
    assign shown_nxt = load | shown;

    seven_segments_rom u_rom (
        .digit (digit_nxt),
        .seg   (rom_seg)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            digit_q <= 4'd0;
            shown   <= 1'b0;
            seg_q   <= DRIVE_OFF;
        end else begin
            digit_q <= digit_nxt;
            shown   <= shown_nxt;
            if (blank)
                seg_q <= DRIVE_OFF;
            else if (shown_nxt)
                seg_q <= apply_polarity(rom_seg, ACTIVE_LOW);
            else
                seg_q <= DRIVE_OFF;
        end
    end

    assign Seven = seg_q;

endmodule

// File: tb/tb_seven_segments.sv
// tb/tb_seven_segments.sv - scoreboard bench for seven_segments, both polarities, honours SEVEN_SEGMENTS_OPGLYPH_EN
module tb_seven_segments;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] digit = 4'd0;
    logic       load = 1'b0;
    logic       blank = 1'b0;
    logic [6:0] seven_lo;
    logic [6:0] seven_hi;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [6:0] lo;
        logic [6:0] hi;
    } exp_t;

    exp_t  sb[$];
    string sb_name[$];

    logic [6:0] enc [16];
    logic [3:0] m_digit;
    bit         m_shown;

    always #5 CLK = ~CLK;

    seven_segments #(.ACTIVE_LOW(1'b1)) dut_lo (
        .CLK   (CLK),
        .RST   (RST),
        .digit (digit),
        .load  (load),
        .blank (blank),
        .Seven (seven_lo)
    );

    seven_segments #(.ACTIVE_LOW(1'b0)) dut_hi (
        .CLK   (CLK),
        .RST   (RST),
        .digit (digit),
        .load  (load),
        .blank (blank),
        .Seven (seven_hi)
    );

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Drive one cycle of stimulus and queue what both displays must show after the next edge
    task automatic step(input bit ld, input bit bl, input logic [3:0] d, input string name);
        exp_t e;
        @(negedge CLK);
        load  = ld;
        blank = bl;
        digit = d;
        if (ld) begin
            m_digit = d;
            m_shown = 1'b1;
        end
        e.hi = (!bl && m_shown) ? enc[m_digit] : 7'h00;
        e.lo = ~e.hi;
        sb.push_back(e);
        sb_name.push_back(name);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++)
            @(posedge CLK);
        #2;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
            sb.delete();
            sb_name.delete();
        end
    endtask

    initial begin
        forever begin
            exp_t  e;
            string n;
            @(posedge CLK);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n = sb_name.pop_front();
                check({n, "_lo"}, seven_lo, e.lo);
                check({n, "_hi"}, seven_hi, e.hi);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
`ifdef SEVEN_SEGMENTS_OPGLYPH_EN
        enc = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h46, 7'h40, 7'h76, 7'h52, 7'h48, 7'h39};
`else
        enc = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
`endif
        m_digit = 4'd0;
        m_shown = 1'b0;

        #12;
        check("reset_lo", seven_lo, 7'h7F);
        check("reset_hi", seven_hi, 7'h00);
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'(i + 5), "idle_unloaded");

        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 4'(i), "sweep");

        step(1'b1, 1'b0, 4'd7, "hold_load");
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 4'd3, "hold");

        step(1'b1, 1'b0, 4'd5, "blank_load5");
        step(1'b0, 1'b1, 4'd5, "blank_on");
        step(1'b1, 1'b1, 4'd9, "blank_load9");
        step(1'b0, 1'b0, 4'd9, "blank_release");

        step(1'b1, 1'b0, 4'd4, "b2b_4");
        step(1'b1, 1'b0, 4'd6, "b2b_6");
        drain();

        // Asynchronous reset mid-cycle while a digit is showing
        @(posedge CLK);
        #3;
        load = 1'b0;
        blank = 1'b0;
        RST = 1'b1;
        #1;
        check("async_reset_lo", seven_lo, 7'h7F);
        check("async_reset_hi", seven_hi, 7'h00);
        m_digit = 4'd0;
        m_shown = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'd8, "post_reset");

        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0),
                 4'($urandom_range(0, 15)), "random");
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
